// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 neighbourhood generator built from two line buffers and a shift window
module conv_window_gen #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_pixel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9*DW-1:0] window,
  output logic            out_last,
  output logic            frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   lb0_q [IMG_W];
  logic [DW-1:0]   lb1_q [IMG_W];
  logic [9*DW-1:0] sw_q, sw_d, win_q;
  logic            valid_q, last_q, done_q;
  logic            acc, take, last_col, last_row, wv;
  assign in_ready   = !valid_q | out_ready;
  assign acc        = in_valid & in_ready;
  assign take       = valid_q & out_ready;
  assign last_col   = col_q == CW'(IMG_W - 1);
  assign last_row   = row_q == RW'(IMG_H - 1);
  assign wv         = (row_q >= RW'(2)) & (col_q >= CW'(2));
  assign out_valid  = valid_q;
  assign window     = win_q;
  assign out_last   = last_q;
  assign frame_done = done_q;
  // Raster position and left-shifted window; right column is {row-2, row-1, current} pixels
  always_comb begin
    col_d = acc ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = (acc & last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
    sw_d  = acc ? {in_pixel, sw_q[9*DW-1:7*DW], lb0_q[col_q], sw_q[6*DW-1:4*DW],
                   lb1_q[col_q], sw_q[3*DW-1:DW]} : sw_q;
  end
  // Line buffers age one row per accepted pixel; contents need no reset since borders mask them
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= in_pixel;
    end
  end
  // Counters, shift window and the single output register that holds while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      sw_q    <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      sw_q   <= sw_d;
      done_q <= take & last_q;
      if (in_ready) begin
        valid_q <= acc & wv;
        win_q   <= sw_d;
        last_q  <= acc & wv & last_row & last_col;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for conv_window_gen on a 4x4 and a 256x256 instance
module tb_conv_window_gen;
  typedef struct packed {
    logic [71:0] w;
    logic        l;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1, s_out_last, s_frame_done;
  logic [7:0] s_in_pixel = '0;
  logic [71:0] s_window;
  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_last, b_frame_done;
  logic [7:0] b_in_pixel = '0;
  logic [71:0] b_window;
  exp_t sq[$];
  exp_t bq[$];
  logic [7:0] bimg [65536];
  int checks = 0, errors = 0, s_fd = 0, b_fd = 0, b_win = 0;
  always #5 clk = ~clk;
  conv_window_gen #(.IMG_W(4), .IMG_H(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pixel(s_in_pixel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .window(s_window), .out_last(s_out_last),
    .frame_done(s_frame_done));
  conv_window_gen #(.IMG_W(256), .IMG_H(256), .DW(8)) dut_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .window(b_window), .out_last(b_out_last),
    .frame_done(b_frame_done));
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Reference neighbourhood of a 4x4 frame whose pixel (r,c) is base + 4r + c
  function automatic logic [71:0] win4(input int base, input int r, input int c);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(base + (r - 2 + k / 3) * 4 + (c - 2 + k % 3));
    return w;
  endfunction
  function automatic logic [71:0] win_big(input int r, input int c);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = bimg[(r - 2 + k / 3) * 256 + (c - 2 + k % 3)];
    return w;
  endfunction
  task automatic push_small(input int base);
    for (int r = 2; r < 4; r++)
      for (int c = 2; c < 4; c++) sq.push_back('{w: win4(base, r, c), l: (r == 3 && c == 3)});
  endtask
  task automatic put(input logic [7:0] p, input bit rnd);
    if (rnd)
      while (($urandom & 1) == 0) begin
        s_in_valid = 1'b0;
        @(posedge clk); #1;
      end
    s_in_valid = 1'b1;
    s_in_pixel = p;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_in_ready) break;
    end
    if (!s_in_ready) chk("in_ready_timeout", 72'(s_in_ready), 72'd1);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask
  task automatic frame_small(input int base, input bit rnd);
    for (int i = 0; i < 16; i++) put(8'(base + i), rnd);
  endtask
  task automatic drain_small(input int fd_exp);
    for (int i = 0; i < 200 && sq.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("small_queue_empty", 72'(sq.size()), 72'd0);
    chk("small_frame_done_count", 72'(s_fd), 72'(fd_exp));
  endtask
  // Small-instance monitor: every output handshake pops one expected window
  always @(negedge clk) begin
    if (s_frame_done) s_fd++;
    if (s_out_valid && s_out_ready) begin
      if (sq.size() == 0) chk("small_unexpected_window", s_window, 72'd0);
      else begin
        exp_t e;
        e = sq.pop_front();
        chk("small_window", s_window, e.w);
        chk("small_out_last", 72'(s_out_last), 72'(e.l));
      end
    end
  end
  // Large-instance monitor
  always @(negedge clk) begin
    if (b_frame_done) b_fd++;
    if (b_out_valid && b_out_ready) begin
      b_win++;
      if (bq.size() == 0) chk("big_unexpected_window", b_window, 72'd0);
      else begin
        exp_t e;
        e = bq.pop_front();
        chk("big_window", b_window, e.w);
        chk("big_out_last", 72'(b_out_last), 72'(e.l));
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 72'(s_out_valid), 72'd0);
    chk("reset_window", s_window, 72'd0);
    chk("reset_out_last", 72'(s_out_last), 72'd0);
    chk("reset_frame_done", 72'(s_frame_done), 72'd0);
    chk("reset_in_ready", 72'(s_in_ready), 72'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    // T1: plain 4x4 frame
    push_small(0);
    frame_small(0, 1'b0);
    drain_small(1);
    // T2: stall the consumer for 5 cycles on the first window
    push_small(0);
    fork
      frame_small(0, 1'b0);
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clk); #1;
          if (s_out_valid) break;
        end
        s_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_window", s_window, win4(0, 2, 2));
          chk("stall_out_valid", 72'(s_out_valid), 72'd1);
          chk("stall_in_ready", 72'(s_in_ready), 72'd0);
          @(posedge clk); #1;
        end
        s_out_ready = 1'b1;
      end
    join
    drain_small(2);
    // T3: random input bubbles
    push_small(0);
    frame_small(0, 1'b1);
    drain_small(3);
    // T4: two back-to-back frames
    push_small(0);
    push_small(100);
    frame_small(0, 1'b0);
    frame_small(100, 1'b0);
    drain_small(5);
    // T5: reset mid-frame, then a clean frame
    for (int i = 0; i < 7; i++) put(8'(i), 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", 72'(s_out_valid), 72'd0);
    chk("midreset_in_ready", 72'(s_in_ready), 72'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    push_small(0);
    frame_small(0, 1'b0);
    drain_small(6);
    // T6: full-size random frame
    for (int i = 0; i < 65536; i++) bimg[i] = 8'($urandom);
    for (int r = 2; r < 256; r++)
      for (int c = 2; c < 256; c++) bq.push_back('{w: win_big(r, c), l: (r == 255 && c == 255)});
    b_in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      b_in_pixel = bimg[i];
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    for (int i = 0; i < 300 && bq.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("big_queue_empty", 72'(bq.size()), 72'd0);
    chk("big_window_count", 72'(b_win), 72'd64516);
    chk("big_frame_done_count", 72'(b_fd), 72'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
